// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM states, scan-code
// prefix bytes and the odd-parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small synchronous FIFO with a combinational head read; a push into a full
// FIFO without a simultaneous pop is dropped and flagged on o_drop.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             pop_ok, push_ok;

  assign o_empty = (count_reg == '0);
  assign o_full  = (count_reg == FULL_COUNT);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_drop  = i_push && o_full && !pop_ok;
  assign o_rdata = o_empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= i_wdata;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with byte FIFO. Optional macro
// PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into flags on the following byte.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_extended,
  output logic       o_release,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overflow
);

`ifdef PS2_PREFIX_DECODE_EN
  localparam int ENTRY_W = 10;
`else
  localparam int ENTRY_W = 8;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_reg, data_sync_reg;
  logic                   ps2_clk_last_reg;
  logic                   ps2_fall, ps2_bit;

  ps2_state_e    state_reg, state_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_next, tmo_inc;
  logic          frame_ok, parity_err, frame_err;

  logic               push;
  logic [ENTRY_W-1:0] push_data, fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_drop, pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync_reg     <= '1;
      data_sync_reg    <= '1;
      ps2_clk_last_reg <= 1'b1;
    end else begin
      clk_sync_reg     <= {clk_sync_reg[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync_reg    <= {data_sync_reg[SYNC_STAGES-2:0], i_ps2_data};
      ps2_clk_last_reg <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = ps2_clk_last_reg && !clk_sync_reg[SYNC_STAGES-1];
  assign ps2_bit  = data_sync_reg[SYNC_STAGES-1];
  assign tmo_inc  = tmo_cnt_reg + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tmo_cnt_reg <= tmo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    tmo_next     = '0;
    frame_ok     = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    // The timeout fires in the cycle the counter would step onto its last value.
    if (state_reg != ST_IDLE && !ps2_fall) begin
      if (tmo_inc == TMO_LAST) begin
        state_next   = ST_IDLE;
        bit_idx_next = '0;
        frame_err    = 1'b1;
      end else begin
        tmo_next = tmo_inc;
      end
    end
    if (ps2_fall) begin
      case (state_reg)
        ST_IDLE: begin
          if (!ps2_bit) begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
          end
        end
        ST_DATA: begin
          shift_next   = {ps2_bit, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) state_next = ST_PARITY;
        end
        ST_PARITY: begin
          parity_next = ps2_bit;
          state_next  = ST_STOP;
        end
        default: begin
          state_next = ST_IDLE;
          if (!ps2_bit)                               frame_err  = 1'b1;
          else if (odd_parity_ok(shift_reg, parity_reg)) frame_ok   = 1'b1;
          else                                        parity_err = 1'b1;
        end
      endcase
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_reg, ext_next, rel_reg, rel_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_reg <= 1'b0;
      rel_reg <= 1'b0;
    end else begin
      ext_reg <= ext_next;
      rel_reg <= rel_next;
    end
  end

  always_comb begin
    ext_next  = ext_reg;
    rel_next  = rel_reg;
    push      = 1'b0;
    push_data = {rel_reg, ext_reg, shift_reg};
    if (parity_err || frame_err) begin
      ext_next = 1'b0;
      rel_next = 1'b0;
    end else if (frame_ok) begin
      if (shift_reg == PS2_PREFIX_EXT)      ext_next = 1'b1;
      else if (shift_reg == PS2_PREFIX_REL) rel_next = 1'b1;
      else begin
        push     = 1'b1;
        ext_next = 1'b0;
        rel_next = 1'b0;
      end
    end
  end

  assign o_extended = fifo_rdata[8];
  assign o_release  = fifo_rdata[9];
`else
  assign push       = frame_ok;
  assign push_data  = shift_reg;
  assign o_extended = 1'b0;
  assign o_release  = 1'b0;
`endif

  ps2_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_wdata (push_data),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_drop  (fifo_drop)
  );

  assign o_valid      = !fifo_empty;
  assign pop          = o_valid && i_ready;
  assign o_data       = fifo_rdata[7:0];
  assign o_parity_err = parity_err;
  assign o_frame_err  = frame_err;
  // A drop can only happen while full; the qualifier documents that.
  assign o_overflow   = fifo_drop && fifo_full;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of single frames plus hand-written
// overflow, timeout, prefix and mid-frame reset sequences.
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int TIMEOUT_CYCLES = 200;
  localparam int SYNC_STAGES    = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int HALF           = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_data = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_extended, o_release, o_parity_err, o_frame_err, o_overflow;

  ps2_receiver #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_extended   (o_extended),
    .o_release    (o_release),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  int ferr_cyc = -1, valid_rise_cyc = -1, last_fall_cyc = 0;
  logic valid_q = 1'b0;
  logic [9:0] popped[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: count pulses and record every accepted head entry {rel, ext, data}.
  always @(negedge i_clk) begin
    if (o_parity_err) perr_cnt++;
    if (o_frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (o_overflow) ovf_cnt++;
    if (o_valid && !valid_q) valid_rise_cyc = cyc;
    valid_q = o_valid;
    if (o_valid && i_ready) popped.push_back({o_release, o_extended, o_data});
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clear_mon();
    perr_cnt = 0;
    ferr_cnt = 0;
    ovf_cnt = 0;
    ferr_cyc = -1;
    valid_rise_cyc = -1;
    popped.delete();
  endtask

  task automatic set_ready(input logic b);
    @(posedge i_clk);
    #1 i_ready = b;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge i_clk);
    i_ps2_data = b;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    i_ps2_data = 1'b1;
    repeat (4 * HALF) @(negedge i_clk);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //            data   par   stop  push  perr  ferr
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (5) @(negedge i_clk);
    check("reset outputs",
          {o_valid, o_data, o_extended, o_release, o_parity_err, o_frame_err, o_overflow}, '0);
    check("reset state", dut.state_reg, ST_IDLE);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    set_ready(1'b1);

    // Single-frame table
    for (int i = 0; i < 9; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      check($sformatf("vec%0d pushes", i), popped.size(), vecs[i].exp_push);
      if (vecs[i].exp_push && popped.size() > 0) begin
        check($sformatf("vec%0d data", i), popped[0], {2'b00, vecs[i].data});
        // Edge is seen SYNC_STAGES cycles after the drive; o_valid one cycle later.
        check($sformatf("vec%0d valid latency", i), valid_rise_cyc - last_fall_cyc, SYNC_STAGES + 1);
      end
      check($sformatf("vec%0d parity_err pulses", i), perr_cnt, vecs[i].exp_perr);
      check($sformatf("vec%0d frame_err pulses", i), ferr_cnt, vecs[i].exp_ferr);
    end

    // Overflow: five frames into a four-entry FIFO with no consumer
    set_ready(1'b0);
    clear_mon();
    for (int k = 1; k <= 4; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1);
    check("ovf after 4 frames", ovf_cnt, 0);
    send_frame(8'h05, odd_par(8'h05), 1'b1);
    check("ovf on 5th frame", ovf_cnt, 1);
    check("head while full", o_data, 8'h01);
    set_ready(1'b1);
    repeat (10) @(negedge i_clk);
    check("drain count", popped.size(), 4);
    for (int k = 0; k < 4 && k < popped.size(); k++)
      check($sformatf("drain %0d", k), popped[k], k + 1);

    // Timeout after four data bits
    clear_mon();
    ps2_bit(1'b0);
    for (int k = 0; k < 4; k++) ps2_bit(1'b1);
    for (int w = 0; w < TIMEOUT_CYCLES + 100 && ferr_cnt == 0; w++) @(negedge i_clk);
    check("timeout latency", ferr_cyc - last_fall_cyc, SYNC_STAGES + TIMEOUT_CYCLES - 1);
    check("timeout pulses", ferr_cnt, 1);
    check("timeout state", dut.state_reg, ST_IDLE);
    clear_mon();
    send_frame(8'h2A, 1'b0, 1'b1);
    check("post-timeout count", popped.size(), 1);
    if (popped.size() > 0) check("post-timeout data", popped[0], 10'h02A);

    // Prefix sequence E0 F0 75
    clear_mon();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
`ifdef PS2_PREFIX_DECODE_EN
    check("prefix count", popped.size(), 1);
    if (popped.size() > 0) check("prefix entry", popped[0], {2'b11, 8'h75});
`else
    check("prefix count", popped.size(), 3);
    if (popped.size() == 3) begin
      check("prefix entry 0", popped[0], 10'h0E0);
      check("prefix entry 1", popped[1], 10'h0F0);
      check("prefix entry 2", popped[2], 10'h075);
    end
`endif

    // Reset pulsed during the parity bit, with a byte waiting in the FIFO
    set_ready(1'b0);
    send_frame(8'h11, odd_par(8'h11), 1'b1);
    check("pre-reset valid", o_valid, 1'b1);
    clear_mon();
    ps2_bit(1'b0);
    for (int k = 0; k < 8; k++) ps2_bit(k[0]);
    @(negedge i_clk);
    i_ps2_data = 1'b0;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("mid-frame reset outputs",
          {o_valid, o_data, o_extended, o_release, o_parity_err, o_frame_err, o_overflow}, '0);
    i_ps2_clk = 1'b1;
    i_ps2_data = 1'b1;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) @(negedge i_clk);
    check("reset err pulses", perr_cnt + ferr_cnt + ovf_cnt, 0);
    check("reset fifo empty", o_valid, 1'b0);
    set_ready(1'b1);
    clear_mon();
    send_frame(8'h33, 1'b1, 1'b1);
    check("post-reset count", popped.size(), 1);
    if (popped.size() > 0) check("post-reset data", popped[0], 10'h033);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, i_clk cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on i_ps2_clk and i_ps2_data (minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, minimum 2).
REQ-004 SHALL have port i_clk, input, 1, system clock; the block uses this single clock.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_ps2_clk, input, 1, raw PS/2 clock line.
REQ-007 SHALL have port i_ps2_data, input, 1, raw PS/2 data line.
REQ-008 SHALL have port o_data, output, 8, byte at FIFO head.
REQ-009 SHALL have port o_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port i_ready, input, 1, consumer accepts the head byte.
REQ-011 SHALL have port o_extended, output, 1, head byte was preceded by 0xE0.
REQ-012 SHALL have port o_release, output, 1, head byte was preceded by 0xF0.
REQ-013 SHALL have port o_parity_err, output, 1, one-cycle pulse on a parity failure.
REQ-014 SHALL have port o_frame_err, output, 1, one-cycle pulse on a bad stop bit or a timeout.
REQ-015 SHALL have port o_overflow, output, 1, one-cycle pulse when a byte is dropped because the FIFO is full.

Function
REQ-016 SHALL detect a falling edge as last-synchronised 1 and current-synchronised 0, and sample the synchronised data in the same cycle.
REQ-017 SHALL implement four states: IDLE, DATA, PARITY and STOP.
REQ-018 In IDLE, an edge with data 0 SHALL move to DATA with bit index 0; an edge with data 1 SHALL stay in IDLE with no error.
REQ-019 In DATA, each edge SHALL store the sampled bit LSB-first; the eighth bit SHALL move to PARITY.
REQ-020 In PARITY, an edge SHALL latch the parity bit and move to STOP.
REQ-021 In STOP, an edge SHALL always return to IDLE, with the outcome set by REQ-022 to REQ-024.
REQ-022 Stop bit 1 with odd parity over the 8 data bits plus the parity bit correct SHALL complete a valid frame.
REQ-023 Stop bit 1 with wrong parity SHALL pulse o_parity_err and discard the byte.
REQ-024 Stop bit 0 SHALL pulse o_frame_err and discard the byte.
REQ-025 Outside IDLE, the timeout counter SHALL clear on every edge and otherwise increment; on reaching TIMEOUT_CYCLES-1 the block SHALL return to IDLE and pulse o_frame_err.
REQ-026 A valid frame SHALL write the FIFO in the STOP-edge cycle; o_valid SHALL assert the following cycle.
REQ-027 A pop SHALL occur on any cycle where o_valid and i_ready are both 1; o_data, o_extended and o_release SHALL present the head entry combinationally from FIFO storage.
REQ-028 A push while the FIFO is full with no pop in the same cycle SHALL drop the byte and pulse o_overflow; FIFO contents SHALL be unchanged.
REQ-029 A simultaneous push and pop while full SHALL succeed with no overflow.
REQ-030 A push and pop on an empty FIFO SHALL behave as push only, since o_valid is 0 in that cycle.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 While i_rst_n is 0: state IDLE; counters, index, pointers and prefix flags 0; synchroniser flops 1; all outputs 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame and produce no error pulse.

Configuration
REQ-034 With macro PS2_PREFIX_DECODE_EN defined, valid bytes 0xE0 and 0xF0 SHALL NOT be pushed; they SHALL set sticky ext and rel flags respectively.
REQ-035 With PS2_PREFIX_DECODE_EN defined, the next non-prefix byte SHALL be pushed with those flags in 10-bit FIFO entries, and the flags SHALL then clear.
REQ-036 With PS2_PREFIX_DECODE_EN defined, a timeout, parity error or frame error SHALL also clear the flags.
REQ-037 Without PS2_PREFIX_DECODE_EN, every valid byte SHALL be pushed, FIFO entries SHALL be 8 bits, and o_extended and o_release SHALL be tied 0.

Structure
REQ-038 Package ps2_pkg SHALL hold the state enum, PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_REL = 8'hF0.
REQ-039 The buffer SHALL be sub-module ps2_sync_fifo, parametrised on WIDTH and DEPTH and providing full, empty and write-drop indication.

Verification
REQ-040 Frame 0x1C with parity 0 and stop 1, i_ready=1 -> o_valid one cycle after the stop edge, o_data=0x1C, no error pulses.
REQ-041 Frame 0x1C with parity 1 -> o_parity_err one pulse, o_valid stays 0.
REQ-042 Five valid frames 0x01..0x05 with FIFO_DEPTH=4 and i_ready=0 -> o_overflow on the fifth frame; pops then return 0x01..0x04.
REQ-043 PS/2 clock stopped after 4 data bits -> o_frame_err exactly TIMEOUT_CYCLES-1 cycles after the last edge; state IDLE; the next frame 0x2A is received correctly.
REQ-044 Sequence E0,F0,75 with PS2_PREFIX_DECODE_EN defined -> single entry 0x75 with o_extended=1 and o_release=1; without the macro -> three entries, both flags 0.
REQ-045 i_rst_n pulsed low during the parity bit -> all outputs 0 with no error pulse; a following frame 0x33 is received correctly.
